// File: rtl/lpm_table_arbiter_if.sv
// Requester and LPM-table signal bundle for lpm_table_arbiter.
// The arbiter connects through the slave modport; the requesters and table connect through the master modport.
interface lpm_table_arbiter_if #(
  parameter int LUT_DEPTH_BITS = 5,
  parameter int NUM_QUEUES     = 8
);
  localparam int EW = 96 + NUM_QUEUES;

  logic [1:0]                  rq_req;
  logic [1:0]                  rq_we;
  logic [2*LUT_DEPTH_BITS-1:0] rq_addr;
  logic [2*EW-1:0]             rq_wdata;
  logic [1:0]                  rq_ack;
  logic [1:0]                  rq_err;
  logic [EW-1:0]               rq_rdata;

  logic                        lpm_rd_req;
  logic                        lpm_wr_req;
  logic [LUT_DEPTH_BITS-1:0]   lpm_rd_addr;
  logic [LUT_DEPTH_BITS-1:0]   lpm_wr_addr;
  logic [31:0]                 lpm_wr_ip;
  logic [31:0]                 lpm_wr_mask;
  logic [31:0]                 lpm_wr_next_hop_ip;
  logic [NUM_QUEUES-1:0]       lpm_wr_oq;
  logic [31:0]                 lpm_rd_ip;
  logic [31:0]                 lpm_rd_mask;
  logic [31:0]                 lpm_rd_next_hop_ip;
  logic [NUM_QUEUES-1:0]       lpm_rd_oq;
  logic                        lpm_rd_ack;
  logic                        lpm_wr_ack;
  logic                        busy;

  modport slave (
    input  rq_req, rq_we, rq_addr, rq_wdata,
    output rq_ack, rq_err, rq_rdata,
    output lpm_rd_req, lpm_wr_req, lpm_rd_addr, lpm_wr_addr,
    output lpm_wr_ip, lpm_wr_mask, lpm_wr_next_hop_ip, lpm_wr_oq,
    input  lpm_rd_ip, lpm_rd_mask, lpm_rd_next_hop_ip, lpm_rd_oq,
    input  lpm_rd_ack, lpm_wr_ack,
    output busy
  );

  modport master (
    output rq_req, rq_we, rq_addr, rq_wdata,
    input  rq_ack, rq_err, rq_rdata,
    input  lpm_rd_req, lpm_wr_req, lpm_rd_addr, lpm_wr_addr,
    input  lpm_wr_ip, lpm_wr_mask, lpm_wr_next_hop_ip, lpm_wr_oq,
    output lpm_rd_ip, lpm_rd_mask, lpm_rd_next_hop_ip, lpm_rd_oq,
    output lpm_rd_ack, lpm_wr_ack,
    input  busy
  );
endinterface

// File: rtl/lpm_table_arbiter.sv
// Round-robin arbiter giving two requesters single-transaction access to an LPM table,
// with a per-transaction ack timeout.
module lpm_table_arbiter #(
  parameter int LUT_DEPTH_BITS = 5,
  parameter int NUM_QUEUES     = 8,
  parameter int TIMEOUT        = 64
) (
  input  logic                clk,
  input  logic                resetn,
  lpm_table_arbiter_if.slave  bus
);
  localparam int EW = 96 + NUM_QUEUES;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int LB = LUT_DEPTH_BITS;

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT_ACK = 2'd2} state_t;

  state_t        state_q, state_d;
  logic          gnt_q, gnt_d;
  logic          last_q, last_d;
  logic          we_q, we_d;
  logic [LB-1:0] addr_q, addr_d;
  logic [EW-1:0] wdata_q, wdata_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rd_req_q, rd_req_d;
  logic          wr_req_q, wr_req_d;
  logic [1:0]    ack_q, ack_d;
  logic [1:0]    err_q, err_d;
  logic [EW-1:0] rdata_q, rdata_d;
  logic          busy_q, busy_d;
  logic [1:0]    eff_req_s;
  logic          sel_s;

  // A requester is not re-granted in its own ack cycle, so a level request held through ack is not replayed.
  always_comb begin
    eff_req_s = bus.rq_req & ~ack_q;
    if (eff_req_s == 2'b11) begin
      sel_s = ~last_q;
    end else begin
      sel_s = eff_req_s[1];
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    last_d   = last_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    rd_req_d = 1'b0;
    wr_req_d = 1'b0;
    ack_d    = 2'b00;
    err_d    = 2'b00;
    rdata_d  = rdata_q;
    case (state_q)
      IDLE: begin
        if (eff_req_s != 2'b00) begin
          gnt_d    = sel_s;
          we_d     = bus.rq_we[sel_s];
          addr_d   = sel_s ? bus.rq_addr[2*LB-1 -: LB] : bus.rq_addr[LB-1:0];
          wdata_d  = sel_s ? bus.rq_wdata[2*EW-1 -: EW] : bus.rq_wdata[EW-1:0];
          wr_req_d = bus.rq_we[sel_s];
          rd_req_d = ~bus.rq_we[sel_s];
          cnt_d    = CW'(0);
          state_d  = ISSUE;
        end else begin
          state_d  = IDLE;
        end
      end
      ISSUE: begin
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        cnt_d = cnt_q + CW'(1);
        // A matching ack wins even in the cycle the counter would expire.
        if ((we_q && bus.lpm_wr_ack) || (!we_q && bus.lpm_rd_ack)) begin
          ack_d[gnt_q] = 1'b1;
          last_d       = gnt_q;
          state_d      = IDLE;
          if (!we_q) begin
            rdata_d = {bus.lpm_rd_ip, bus.lpm_rd_mask, bus.lpm_rd_oq, bus.lpm_rd_next_hop_ip};
          end else begin
            rdata_d = rdata_q;
          end
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          ack_d[gnt_q] = 1'b1;
          err_d[gnt_q] = 1'b1;
          last_d       = gnt_q;
          state_d      = IDLE;
        end else begin
          state_d      = WAIT_ACK;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State, holding registers and registered outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      gnt_q    <= 1'b0;
      last_q   <= 1'b1;
      we_q     <= 1'b0;
      addr_q   <= {LB{1'b0}};
      wdata_q  <= {EW{1'b0}};
      cnt_q    <= CW'(0);
      rd_req_q <= 1'b0;
      wr_req_q <= 1'b0;
      ack_q    <= 2'b00;
      err_q    <= 2'b00;
      rdata_q  <= {EW{1'b0}};
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      last_q   <= last_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      rd_req_q <= rd_req_d;
      wr_req_q <= wr_req_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.rq_ack             = ack_q;
  assign bus.rq_err             = err_q;
  assign bus.rq_rdata           = rdata_q;
  assign bus.lpm_rd_req         = rd_req_q;
  assign bus.lpm_wr_req         = wr_req_q;
  assign bus.lpm_rd_addr        = addr_q;
  assign bus.lpm_wr_addr        = addr_q;
  assign bus.lpm_wr_ip          = wdata_q[EW-1 -: 32];
  assign bus.lpm_wr_mask        = wdata_q[EW-33 -: 32];
  assign bus.lpm_wr_oq          = wdata_q[32 +: NUM_QUEUES];
  assign bus.lpm_wr_next_hop_ip = wdata_q[31:0];
  assign bus.busy               = busy_q;
endmodule

// File: doc/lpm_table_arbiter.md
LPM_TABLE_ARBITER -- requirements
Module: lpm_table_arbiter

Interface
REQ-001 SHALL have parameter LUT_DEPTH_BITS, default 5, LPM table address width.
REQ-002 SHALL have parameter NUM_QUEUES, default 8, output-queue one-hot width.
REQ-003 SHALL have parameter TIMEOUT, default 64, cycles allowed for a table ack.
REQ-004 SHALL define EW = 96+NUM_QUEUES: one entry packed {ip[31:0], mask[31:0], oq[NUM_QUEUES-1:0], next_hop_ip[31:0]}, MSB first.
REQ-005 SHALL have clk, input, 1: single clock; all logic on its rising edge.
REQ-006 SHALL have resetn, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have rq_req, input, 2: per-requester level request, bit 0 = host registers, bit 1 = route-update engine.
REQ-008 SHALL have rq_we, input, 2: per-requester 1 = write, 0 = read.
REQ-009 SHALL have rq_addr, input, 2*LUT_DEPTH_BITS: requester i at slice i.
REQ-010 SHALL have rq_wdata, input, 2*EW: requester i write entry at slice i.
REQ-011 SHALL have rq_ack, output, 2: one-cycle completion pulse per requester.
REQ-012 SHALL have rq_err, output, 2: one-cycle timeout flag, coincident with rq_ack.
REQ-013 SHALL have rq_rdata, output, EW: read entry, valid in the rq_ack cycle of a read.
REQ-014 SHALL have lpm_rd_req/lpm_wr_req, output, 1 each; lpm_rd_addr/lpm_wr_addr, output, LUT_DEPTH_BITS each.
REQ-015 SHALL have lpm_wr_ip, lpm_wr_mask, lpm_wr_next_hop_ip (output, 32 each) and lpm_wr_oq (output, NUM_QUEUES).
REQ-016 SHALL have lpm_rd_ip, lpm_rd_mask, lpm_rd_next_hop_ip (input, 32 each), lpm_rd_oq (input, NUM_QUEUES), lpm_rd_ack and lpm_wr_ack (input, 1 each).
REQ-017 SHALL have busy, output, 1: high in any state other than IDLE.

Function
REQ-018 SHALL implement states IDLE, ISSUE, WAIT_ACK; exactly one transaction in flight.
REQ-019 IDLE: if any rq_req set, SHALL grant, latch we/addr/wdata of granted requester into holding registers, go ISSUE next cycle.
REQ-020 Arbitration SHALL be round-robin: both requesting -> grant the requester not served last; last_grant resets to 1 (first contention grants requester 0).
REQ-021 ISSUE: SHALL pulse lpm_wr_req (write) or lpm_rd_req (read) for exactly one cycle, then enter WAIT_ACK; both req outputs low in all other cycles.
REQ-022 lpm_* address/data outputs SHALL drive the holding registers, stable from ISSUE until return to IDLE.
REQ-023 WAIT_ACK: on matching ack (lpm_wr_ack for write, lpm_rd_ack for read) SHALL register rq_ack[g]=1 next cycle, update last_grant=g, return to IDLE.
REQ-024 Read completion SHALL capture lpm_rd_* into rq_rdata in the ack cycle; rq_rdata holds until the next read completes.
REQ-025 Timeout counter SHALL clear on ISSUE entry, increment each WAIT_ACK cycle; reaching TIMEOUT without ack -> rq_ack[g]=1 and rq_err[g]=1 for one cycle, return to IDLE; rq_rdata unchanged.
REQ-026 Ack in the same cycle the counter reaches TIMEOUT SHALL count as success (rq_err=0).
REQ-027 Non-matching ack, or any ack outside WAIT_ACK, SHALL be ignored.
REQ-028 Requester deasserting rq_req mid-transaction SHALL NOT abort it; completion still pulses rq_ack.
REQ-029 Requester SHALL hold rq_req and its fields stable until rq_ack and drop rq_req the cycle after; a still-high rq_req in the cycle after rq_ack is treated as a new request.
REQ-030 Minimum request-to-ack latency SHALL be 3 cycles (grant, issue, ack sampled) plus table ack latency.

Reset
REQ-031 resetn low SHALL asynchronously force IDLE, counter 0, last_grant 1, and all outputs (rq_ack, rq_err, rq_rdata, busy, lpm_* req/addr/data) to 0.
REQ-032 Reset mid-transaction SHALL drop the transaction without rq_ack; table acks arriving after reset release are ignored.

Verification
REQ-033 Req0 write addr 3, ip 0x0A000000, mask 0xFF000000, oq 0x04, nh 0; table acks 16 cycles after lpm_wr_req -> single lpm_wr_req pulse with those values, rq_ack[0] one cycle, rq_err=0.
REQ-034 Req1 read addr 7; table returns ip 0xC0A80100, oq 0x10 with lpm_rd_ack -> rq_rdata carries them in the rq_ack[1] cycle.
REQ-035 Both requesting continuously for 4 transactions -> grants 0,1,0,1; never two lpm_*_req in flight.
REQ-036 Write with no table ack -> rq_ack[0]=rq_err[0]=1 exactly TIMEOUT cycles after entering WAIT_ACK; next request serviced normally.
REQ-037 Ack exactly at TIMEOUT -> rq_err=0; stray lpm_rd_ack in IDLE -> no rq_ack.
REQ-038 resetn low during WAIT_ACK -> outputs 0 immediately, no rq_ack; late lpm_wr_ack after release ignored, busy stays 0.
